// File: rtl/virtual_input_encoder_if.sv
// Host-side request/status bundle and receiver strobe lines of the virtual-input encoder.
// The encoder takes the slave view; whoever issues requests takes the master view.
interface virtual_input_encoder_if;
  logic [6:0] target;
  logic       sync_req;
  logic       force_reset;
  logic [2:0] number;
  logic       control;
  logic       busy;
  logic       done;
  logic [6:0] shadow;

  modport master (
    output target, sync_req, force_reset,
    input  number, control, busy, done, shadow
  );

  modport slave (
    input  target, sync_req, force_reset,
    output number, control, busy, done, shadow
  );
endinterface

// File: rtl/virtual_input_encoder.sv
// Drives the number/control toggle protocol so the downstream virtual-input receiver
// reaches a requested 7-bit state, tracking the receiver state in a shadow register.
module virtual_input_encoder #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  virtual_input_encoder_if.slave  vif
);

  localparam logic [6:0] SHADOW_INIT = 7'b0001111;
  localparam logic [2:0] CODE_RESET  = 3'd7;
  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_SCAN  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4,
    S_IDLE  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] number_q, number_d;
  logic [6:0] shadow_q, shadow_d;
  logic [6:0] tgt_q, tgt_d;
  logic       init_q, init_d;

  logic [6:0] diff;
  logic [6:0] lowest_oh;
  logic [2:0] lowest_idx;

  assign diff = tgt_q ^ shadow_q;

  // One-hot of the lowest differing bit; toggles must go out in ascending index order.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_lowest
      if (gi == 0) begin : g_first
        assign lowest_oh[gi] = diff[0];
      end else begin : g_rest
        assign lowest_oh[gi] = diff[gi] & ~(|diff[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    lowest_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (lowest_oh[i]) begin
        lowest_idx = lowest_idx | 3'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    number_d = number_q;
    shadow_d = shadow_q;
    tgt_d    = tgt_q;
    init_d   = init_q;

    case (state_q)
      S_IDLE: begin
        if (vif.force_reset) begin
          number_d = CODE_RESET;
          init_d   = 1'b1;
          cnt_d    = SETUP_LOAD;
          state_d  = S_SETUP;
        end else if (vif.sync_req) begin
          tgt_d   = vif.target;
          init_d  = 1'b0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (diff == 7'd0) begin
          state_d = S_DONE;
        end else begin
          number_d = lowest_idx;
          cnt_d    = SETUP_LOAD;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = PULSE_LOAD;
          state_d = S_PULSE;
          // The receiver acts on this rising edge, so the shadow follows it here.
          if (number_q == CODE_RESET) begin
            shadow_d = SHADOW_INIT;
          end else begin
            shadow_d = shadow_q ^ (7'd1 << number_q);
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_PULSE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = HOLD_LOAD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = init_q ? S_DONE : S_SCAN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset parks the FSM in SETUP with code 7 loaded, so release always resynchronises the link.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_SETUP;
      cnt_q    <= SETUP_LOAD;
      number_q <= CODE_RESET;
      shadow_q <= SHADOW_INIT;
      tgt_q    <= SHADOW_INIT;
      init_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      number_q <= number_d;
      shadow_q <= shadow_d;
      tgt_q    <= tgt_d;
      init_q   <= init_d;
    end
  end

  assign vif.number  = number_q;
  assign vif.control = (state_q == S_PULSE);
  assign vif.busy    = (state_q != S_IDLE);
  assign vif.done    = (state_q == S_DONE);
  assign vif.shadow  = shadow_q;

endmodule

// File: tb/tb_virtual_input_encoder.sv
// Directed bench for virtual_input_encoder: two instances (default timing and a 1/5/3 sweep),
// a scoreboard of expected strobes/done pulses and a behavioural receiver model.
module tb_virtual_input_encoder;

  localparam int S_A = 2, P_A = 2, H_A = 2;
  localparam int S_B = 1, P_B = 5, H_B = 3;
  localparam int T_A = 1 + S_A + P_A + H_A;
  localparam int T_B = 1 + S_B + P_B + H_B;
  localparam logic [6:0] INIT = 7'b0001111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  virtual_input_encoder_if if_a ();
  virtual_input_encoder_if if_b ();

  virtual_input_encoder #(.SETUP_CYC(S_A), .PULSE_CYC(P_A), .HOLD_CYC(H_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (if_a)
  );

  virtual_input_encoder #(.SETUP_CYC(S_B), .PULSE_CYC(P_B), .HOLD_CYC(H_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (if_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int dut;
    int code;
    int cyc;
  } ev_t;

  ev_t        rise_q[$];
  ev_t        done_q[$];
  logic [6:0] ref_state[2];

  logic [2:0] m_num[2];
  logic       m_ctl[2];
  logic       m_done[2];
  logic [6:0] m_shadow[2];

  assign m_num[0]    = if_a.number;
  assign m_num[1]    = if_b.number;
  assign m_ctl[0]    = if_a.control;
  assign m_ctl[1]    = if_b.control;
  assign m_done[0]   = if_a.done;
  assign m_done[1]   = if_b.done;
  assign m_shadow[0] = if_a.shadow;
  assign m_shadow[1] = if_b.shadow;

  function automatic int s_of(input int d);
    return (d == 0) ? S_A : S_B;
  endfunction
  function automatic int p_of(input int d);
    return (d == 0) ? P_A : P_B;
  endfunction
  function automatic int h_of(input int d);
    return (d == 0) ? H_A : H_B;
  endfunction
  function automatic int t_of(input int d);
    return (d == 0) ? T_A : T_B;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input bit is_rise, input int d, input int code, input int at);
    ev_t e;
    e.dut  = d;
    e.code = code;
    e.cyc  = at;
    if (is_rise) rise_q.push_back(e);
    else         done_q.push_back(e);
  endtask

  task automatic pop_ev(input bit is_rise, input int d, output bit found, output ev_t e);
    found = 1'b0;
    e.dut = 0; e.code = 0; e.cyc = 0;
    if (is_rise) begin
      for (int i = 0; i < rise_q.size(); i++) begin
        if (rise_q[i].dut == d) begin
          e = rise_q[i]; rise_q.delete(i); found = 1'b1; break;
        end
      end
    end else begin
      for (int i = 0; i < done_q.size(); i++) begin
        if (done_q[i].dut == d) begin
          e = done_q[i]; done_q.delete(i); found = 1'b1; break;
        end
      end
    end
  endtask

  task automatic purge(input int d);
    bit  found;
    ev_t e;
    do pop_ev(1'b1, d, found, e); while (found);
    do pop_ev(1'b0, d, found, e); while (found);
  endtask

  // Receiver model: toggles on each control rise, code 7 restores buttons=1/switches=0.
  logic [6:0] model[2];

  task automatic on_rise(input int d);
    bit  found;
    ev_t e;
    pop_ev(1'b1, d, found, e);
    check($sformatf("rise_expected_d%0d", d), found, 1);
    if (found) begin
      check($sformatf("rise_code_d%0d", d), m_num[d], e.code);
      check($sformatf("rise_cycle_d%0d", d), cyc, e.cyc);
    end
    if (m_num[d] == 3'd7) model[d] = INIT;
    else model[d][m_num[d]] = ~model[d][m_num[d]];
    check($sformatf("model_vs_shadow_d%0d", d), m_shadow[d], model[d]);
  endtask

  task automatic on_done(input int d);
    bit  found;
    ev_t e;
    pop_ev(1'b0, d, found, e);
    check($sformatf("done_expected_d%0d", d), found, 1);
    if (found) check($sformatf("done_cycle_d%0d", d), cyc, e.cyc);
    check($sformatf("done_shadow_model_d%0d", d), m_shadow[d], model[d]);
  endtask

  logic [2:0] p_num[2];
  logic       p_ctl[2];
  logic [6:0] p_shadow[2];
  int         since_chg[2], since_fall[2], hi_len[2];
  logic       p_rst;

  // Output monitor, sampled on the falling edge; checks are skipped for edges that saw reset.
  initial begin
    logic rise, fall;
    for (int d = 0; d < 2; d++) begin
      p_num[d] = '0; p_ctl[d] = 1'b0; p_shadow[d] = '0; model[d] = '0;
      since_chg[d] = 0; since_fall[d] = 1000; hi_len[d] = 0;
    end
    p_rst = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rise = m_ctl[d] && !p_ctl[d];
        fall = !m_ctl[d] && p_ctl[d];
        if (p_rst) begin
          if (rise) begin
            check($sformatf("setup_time_d%0d", d), since_chg[d] >= s_of(d), 1);
            on_rise(d);
          end
          if (fall) check($sformatf("pulse_len_d%0d", d), hi_len[d], p_of(d));
          if (m_num[d] !== p_num[d]) begin
            check($sformatf("num_change_ctl_low_d%0d", d), {p_ctl[d], m_ctl[d]}, 2'b00);
            check($sformatf("hold_time_d%0d", d), since_fall[d] > h_of(d), 1);
          end
          if (m_shadow[d] !== p_shadow[d]) check($sformatf("shadow_only_on_rise_d%0d", d), rise, 1);
          if (m_done[d]) on_done(d);
        end
        since_chg[d]  = (m_num[d] !== p_num[d]) ? 1 : since_chg[d] + 1;
        since_fall[d] = fall ? 1 : since_fall[d] + 1;
        hi_len[d]     = m_ctl[d] ? hi_len[d] + 1 : 0;
        p_num[d]      = m_num[d];
        p_ctl[d]      = m_ctl[d];
        p_shadow[d]   = m_shadow[d];
      end
      p_rst = rst_n;
    end
  end

  task automatic release_reset();
    for (int d = 0; d < 2; d++) begin
      push_ev(1'b1, d, 7, cyc + s_of(d));
      push_ev(1'b0, d, 0, cyc + s_of(d) + p_of(d) + h_of(d));
      ref_state[d] = INIT;
    end
    rst_n = 1'b1;
  endtask

  task automatic req_sync(input int d, input logic [6:0] tgt);
    logic [6:0] diff;
    int         k;
    diff = tgt ^ ref_state[d];
    k = 0;
    for (int i = 0; i < 7; i++) begin
      if (diff[i]) begin
        push_ev(1'b1, d, i, cyc + 2 + s_of(d) + k * t_of(d));
        k++;
      end
    end
    push_ev(1'b0, d, 0, cyc + k * t_of(d) + 2);
    ref_state[d] = tgt;
    if (d == 0) begin if_a.target = tgt; if_a.sync_req = 1'b1; end
    else        begin if_b.target = tgt; if_b.sync_req = 1'b1; end
    @(posedge clk); #1;
    if_a.sync_req = 1'b0;
    if_b.sync_req = 1'b0;
  endtask

  task automatic req_force_a(input bit also_sync, input logic [6:0] tgt);
    push_ev(1'b1, 0, 7, cyc + 1 + S_A);
    push_ev(1'b0, 0, 0, cyc + 1 + S_A + P_A + H_A);
    ref_state[0] = INIT;
    if_a.target = tgt;
    if_a.force_reset = 1'b1;
    if_a.sync_req = also_sync;
    @(posedge clk); #1;
    if_a.force_reset = 1'b0;
    if_a.sync_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!if_a.busy && !if_b.busy) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check(tag, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    if_a.target = '0; if_a.sync_req = 1'b0; if_a.force_reset = 1'b0;
    if_b.target = '0; if_b.sync_req = 1'b0; if_b.force_reset = 1'b0;
    ref_state[0] = INIT;
    ref_state[1] = INIT;

    // 1: reset values, then release and the code-7 init sequence
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_number_a", if_a.number, 3'd7);
    check("rst_control_a", if_a.control, 1'b0);
    check("rst_busy_a", if_a.busy, 1'b1);
    check("rst_done_a", if_a.done, 1'b0);
    check("rst_shadow_a", if_a.shadow, INIT);
    check("rst_number_b", if_b.number, 3'd7);
    check("rst_control_b", if_b.control, 1'b0);
    check("rst_shadow_b", if_b.shadow, INIT);
    release_reset();
    wait_idle("idle_after_reset");
    check("init_busy_a", if_a.busy, 1'b0);
    check("init_shadow_a", if_a.shadow, INIT);
    check("init_shadow_b", if_b.shadow, INIT);

    // 2: no-op sync, busy for SCAN and DONE only
    req_sync(0, INIT);
    check("noop_busy_scan", if_a.busy, 1'b1);
    check("noop_done_early", if_a.done, 1'b0);
    @(posedge clk); #1;
    check("noop_busy_done", if_a.busy, 1'b1);
    check("noop_done", if_a.done, 1'b1);
    @(posedge clk); #1;
    check("noop_busy_idle", if_a.busy, 1'b0);

    // 3: codes 0, 3, 6 in ascending order
    req_sync(0, 7'b1000110);
    wait_idle("idle_after_multi");
    check("multi_shadow", if_a.shadow, ref_state[0]);

    // 4: force_reset wins over sync_req; requests while busy are dropped
    req_force_a(1'b1, 7'b1111111);
    check("busy_during_force", if_a.busy, 1'b1);
    if_a.target = 7'b1111111;
    if_a.sync_req = 1'b1;
    @(posedge clk); #1;
    if_a.sync_req = 1'b0;
    wait_idle("idle_after_force");
    repeat (4) @(posedge clk);
    #1;
    check("force_stays_idle", if_a.busy, 1'b0);
    check("force_shadow", if_a.shadow, INIT);

    // 5: reset during the pulse of a code-2 toggle
    req_sync(0, 7'b0001011);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if_a.control) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("mid_pulse_seen", seen, 1'b1);
    check("mid_pulse_number", if_a.number, 3'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_control", if_a.control, 1'b0);
    check("mid_rst_number", if_a.number, 3'd7);
    check("mid_rst_shadow", if_a.shadow, INIT);
    purge(0);
    release_reset();
    wait_idle("idle_after_mid_reset");
    check("mid_final_shadow", if_a.shadow, INIT);

    // 6: 1/5/3 timing instance, single toggle then two toggles 10 cycles apart
    req_sync(1, 7'b0001110);
    wait_idle("idle_after_b_single");
    check("b_single_shadow", if_b.shadow, 7'b0001110);
    req_sync(1, 7'b0101100);
    wait_idle("idle_after_b_double");
    check("b_double_shadow", if_b.shadow, 7'b0101100);

    repeat (2) @(posedge clk);
    #1;
    check("rise_queue_empty", rise_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
